// File: rtl/cache_pkg.sv
// Shared types for the miss-handling sequencer: MESI encoding, sequencer states
// and a per-way state extraction helper.
package cache_pkg;

  localparam int NUM_WAYS = 4;

  typedef enum logic [1:0] {
    MESI_I = 2'b00,
    MESI_S = 2'b01,
    MESI_E = 2'b10,
    MESI_M = 2'b11
  } mesi_t;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_LOOKUP    = 3'd1,
    ST_SELECT    = 3'd2,
    ST_WB        = 3'd3,
    ST_FILL_REQ  = 3'd4,
    ST_FILL_WAIT = 3'd5,
    ST_INSTALL   = 3'd6
  } evict_fsm_t;

  function automatic logic [1:0] way_state(input logic [NUM_WAYS*2-1:0] states,
                                           input logic [1:0]            way);
    return states[{way, 1'b0} +: 2];
  endfunction

endpackage

// File: rtl/cache_victim_pick.sv
// Victim way selection from the registered set states and the PLRU answer.
// CACHE_INV_FIRST_EN: prefer the lowest-index Invalid way over the PLRU choice.
module cache_victim_pick
  import cache_pkg::*;
(
  input  logic [NUM_WAYS*2-1:0] rd_state,
  input  logic [1:0]            plru_evict_way,
  output logic [1:0]            victim_way,
  output logic                  victim_is_m
);

`ifdef CACHE_INV_FIRST_EN
  logic [NUM_WAYS-1:0] inv_mask;

  // Lowest-index Invalid way wins; the PLRU answer is only a fallback.
  always_comb begin
    inv_mask = {NUM_WAYS{1'b0}};
    for (int w = 0; w < NUM_WAYS; w++) begin
      inv_mask[w] = (way_state(rd_state, 2'(w)) == MESI_I);
    end
    casez (inv_mask)
      4'b???1: victim_way = 2'd0;
      4'b??10: victim_way = 2'd1;
      4'b?100: victim_way = 2'd2;
      4'b1000: victim_way = 2'd3;
      default: victim_way = plru_evict_way;
    endcase
  end
`else
  assign victim_way = plru_evict_way;
`endif

  assign victim_is_m = (way_state(rd_state, victim_way) == MESI_M);

endmodule

// File: rtl/cache_evict_fill_ctrl.sv
// Miss sequencer: read set, pick victim, write back if Modified, fetch and install.
// Victim policy depends on CACHE_INV_FIRST_EN (see cache_victim_pick).
module cache_evict_fill_ctrl
  import cache_pkg::*;
#(
  parameter int SET_W  = 6,
  parameter int TAG_W  = 20,
  parameter int LINE_W = 512
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       miss_valid,
  output logic                       miss_ready,
  input  logic [SET_W-1:0]           miss_set,
  input  logic [TAG_W-1:0]           miss_tag,
  output logic                       rd_en,
  output logic [SET_W-1:0]           rd_set,
  input  logic [NUM_WAYS*2-1:0]      rd_state,
  input  logic [NUM_WAYS*TAG_W-1:0]  rd_tag,
  input  logic [NUM_WAYS*LINE_W-1:0] rd_data,
  output logic                       plru_evict_req,
  input  logic [1:0]                 plru_evict_way,
  output logic                       plru_access_valid,
  output logic [1:0]                 plru_access_way,
  output logic                       wb_valid,
  input  logic                       wb_ready,
  output logic [TAG_W+SET_W-1:0]     wb_addr,
  output logic [LINE_W-1:0]          wb_data,
  output logic                       fill_req_valid,
  input  logic                       fill_req_ready,
  output logic [TAG_W+SET_W-1:0]     fill_req_addr,
  input  logic                       fill_rsp_valid,
  input  logic [LINE_W-1:0]          fill_rsp_data,
  input  logic                       fill_rsp_excl,
  output logic                       wr_en,
  output logic [SET_W-1:0]           wr_set,
  output logic [1:0]                 wr_way,
  output logic [TAG_W-1:0]           wr_tag,
  output logic [1:0]                 wr_state,
  output logic [LINE_W-1:0]          wr_data,
  output logic                       done
);

  evict_fsm_t                 state_q, state_d;
  logic [SET_W-1:0]           set_q, set_d;
  logic [TAG_W-1:0]           tag_q, tag_d;
  logic [1:0]                 way_q, way_d;
  logic [NUM_WAYS*2-1:0]      states_q, states_d;
  logic [NUM_WAYS*TAG_W-1:0]  tags_q, tags_d;
  logic [NUM_WAYS*LINE_W-1:0] data_q, data_d;
  logic [LINE_W-1:0]          fill_data_q, fill_data_d;
  logic                       fill_excl_q, fill_excl_d;
  logic [1:0]                 pick_way;
  logic                       pick_is_m;

  cache_victim_pick u_victim_pick (
    .rd_state       (states_q),
    .plru_evict_way (plru_evict_way),
    .victim_way     (pick_way),
    .victim_is_m    (pick_is_m)
  );

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      set_q       <= {SET_W{1'b0}};
      tag_q       <= {TAG_W{1'b0}};
      way_q       <= 2'd0;
      states_q    <= {(NUM_WAYS*2){1'b0}};
      tags_q      <= {(NUM_WAYS*TAG_W){1'b0}};
      data_q      <= {(NUM_WAYS*LINE_W){1'b0}};
      fill_data_q <= {LINE_W{1'b0}};
      fill_excl_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      set_q       <= set_d;
      tag_q       <= tag_d;
      way_q       <= way_d;
      states_q    <= states_d;
      tags_q      <= tags_d;
      data_q      <= data_d;
      fill_data_q <= fill_data_d;
      fill_excl_q <= fill_excl_d;
    end
  end

  // Next-state and capture logic.
  always_comb begin
    state_d     = state_q;
    set_d       = set_q;
    tag_d       = tag_q;
    way_d       = way_q;
    states_d    = states_q;
    tags_d      = tags_q;
    data_d      = data_q;
    fill_data_d = fill_data_q;
    fill_excl_d = fill_excl_q;
    case (state_q)
      ST_IDLE: begin
        if (miss_valid) begin
          set_d   = miss_set;
          tag_d   = miss_tag;
          state_d = ST_LOOKUP;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LOOKUP: begin
        states_d = rd_state;
        tags_d   = rd_tag;
        data_d   = rd_data;
        state_d  = ST_SELECT;
      end
      ST_SELECT: begin
        way_d   = pick_way;
        state_d = pick_is_m ? ST_WB : ST_FILL_REQ;
      end
      ST_WB: begin
        if (wb_ready) begin
          state_d = ST_FILL_REQ;
        end else begin
          state_d = ST_WB;
        end
      end
      ST_FILL_REQ: begin
        if (fill_req_ready) begin
          state_d = ST_FILL_WAIT;
        end else begin
          state_d = ST_FILL_REQ;
        end
      end
      ST_FILL_WAIT: begin
        if (fill_rsp_valid) begin
          fill_data_d = fill_rsp_data;
          fill_excl_d = fill_rsp_excl;
          state_d     = ST_INSTALL;
        end else begin
          state_d = ST_FILL_WAIT;
        end
      end
      ST_INSTALL: state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // Strobes and handshakes decoded from the current state.
  always_comb begin
    miss_ready        = 1'b0;
    rd_en             = 1'b0;
    plru_evict_req    = 1'b0;
    wb_valid          = 1'b0;
    fill_req_valid    = 1'b0;
    wr_en             = 1'b0;
    plru_access_valid = 1'b0;
    done              = 1'b0;
    case (state_q)
      ST_IDLE: begin
        miss_ready = 1'b1;
        rd_en      = miss_valid;
      end
      ST_SELECT:   plru_evict_req = 1'b1;
      ST_WB:       wb_valid       = 1'b1;
      ST_FILL_REQ: fill_req_valid = 1'b1;
      ST_INSTALL: begin
        wr_en             = 1'b1;
        plru_access_valid = 1'b1;
        done              = 1'b1;
      end
      default: begin
        miss_ready = 1'b0;
      end
    endcase
  end

  assign rd_set          = miss_set;
  assign wb_addr         = {tags_q[way_q*TAG_W +: TAG_W], set_q};
  assign wb_data         = data_q[way_q*LINE_W +: LINE_W];
  assign fill_req_addr   = {tag_q, set_q};
  assign plru_access_way = way_q;
  assign wr_set          = set_q;
  assign wr_way          = way_q;
  assign wr_tag          = tag_q;
  assign wr_state        = fill_excl_q ? MESI_E : MESI_S;
  assign wr_data         = fill_data_q;

endmodule

// File: tb/tb_cache_evict_fill_ctrl.sv
// Randomised and directed bench for cache_evict_fill_ctrl with a transaction-level
// reference model; honours CACHE_INV_FIRST_EN when computing the expected victim.
module tb_cache_evict_fill_ctrl;

  localparam int SET_W  = 6;
  localparam int TAG_W  = 20;
  localparam int LINE_W = 512;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  miss_valid;
  logic                  miss_ready;
  logic [SET_W-1:0]      miss_set;
  logic [TAG_W-1:0]      miss_tag;
  logic                  rd_en;
  logic [SET_W-1:0]      rd_set;
  logic [7:0]            rd_state;
  logic [4*TAG_W-1:0]    rd_tag;
  logic [4*LINE_W-1:0]   rd_data;
  logic                  plru_evict_req;
  logic [1:0]            plru_evict_way;
  logic                  plru_access_valid;
  logic [1:0]            plru_access_way;
  logic                  wb_valid;
  logic                  wb_ready;
  logic [TAG_W+SET_W-1:0] wb_addr;
  logic [LINE_W-1:0]     wb_data;
  logic                  fill_req_valid;
  logic                  fill_req_ready;
  logic [TAG_W+SET_W-1:0] fill_req_addr;
  logic                  fill_rsp_valid;
  logic [LINE_W-1:0]     fill_rsp_data;
  logic                  fill_rsp_excl;
  logic                  wr_en;
  logic [SET_W-1:0]      wr_set;
  logic [1:0]            wr_way;
  logic [TAG_W-1:0]      wr_tag;
  logic [1:0]            wr_state;
  logic [LINE_W-1:0]     wr_data;
  logic                  done;

  int checks = 0;
  int errors = 0;
  int acc_total = 0;

  always #5 clk = ~clk;

  cache_evict_fill_ctrl #(.SET_W(SET_W), .TAG_W(TAG_W), .LINE_W(LINE_W)) dut (
    .clk(clk), .rst(rst),
    .miss_valid(miss_valid), .miss_ready(miss_ready), .miss_set(miss_set), .miss_tag(miss_tag),
    .rd_en(rd_en), .rd_set(rd_set), .rd_state(rd_state), .rd_tag(rd_tag), .rd_data(rd_data),
    .plru_evict_req(plru_evict_req), .plru_evict_way(plru_evict_way),
    .plru_access_valid(plru_access_valid), .plru_access_way(plru_access_way),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_addr(wb_addr), .wb_data(wb_data),
    .fill_req_valid(fill_req_valid), .fill_req_ready(fill_req_ready), .fill_req_addr(fill_req_addr),
    .fill_rsp_valid(fill_rsp_valid), .fill_rsp_data(fill_rsp_data), .fill_rsp_excl(fill_rsp_excl),
    .wr_en(wr_en), .wr_set(wr_set), .wr_way(wr_way), .wr_tag(wr_tag), .wr_state(wr_state),
    .wr_data(wr_data), .done(done)
  );

  task automatic chk(input string tag, input logic [LINE_W-1:0] obs, input logic [LINE_W-1:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  function automatic logic [LINE_W-1:0] rand_line();
    logic [LINE_W-1:0] v;
    v = {LINE_W{1'b0}};
    for (int k = 0; k < LINE_W / 32; k++) v[k*32 +: 32] = $urandom;
    return v;
  endfunction

  // One complete miss: presents the set, plays the PLRU/writeback/fill partners,
  // and compares every observable effect against the rules of the miss flow.
  task automatic run_miss(input logic [SET_W-1:0] s, input logic [TAG_W-1:0] t,
                          input logic [7:0] st, input logic [4*TAG_W-1:0] tg,
                          input logic [1:0] pw, input logic ex,
                          input int wbw, input int rqw, input int fw, input bit do_rst);
    logic [LINE_W-1:0] ld [4];
    logic [LINE_W-1:0] fd;
    int  victim, exp_lat, cyc, acc_cyc, req_cyc, done_cyc;
    int  wb_seen, rq_seen, done_cnt, wr_cnt, acc_cnt, evict_cnt;
    bit  exp_wb, accepted, wb_done, req_done, rsp_sent, finished;
    for (int w = 0; w < 4; w++) ld[w] = rand_line();
    fd = rand_line();
    rd_data = {ld[3], ld[2], ld[1], ld[0]};
    rd_state = st;
    rd_tag = tg;
    plru_evict_way = pw;
    fill_rsp_data = fd;
    fill_rsp_excl = ex;
    miss_set = s;
    miss_tag = t;
    victim = int'(pw);
`ifdef CACHE_INV_FIRST_EN
    for (int w = 3; w >= 0; w--) if (st[2*w +: 2] == 2'b00) victim = w;
`endif
    exp_wb = (st[2*victim +: 2] == 2'b11);
    exp_lat = 5 + (exp_wb ? wbw + 1 : 0) + rqw + fw;
    accepted = 0; wb_done = 0; req_done = 0; rsp_sent = 0; finished = 0;
    acc_cyc = 0; req_cyc = 0; done_cyc = 0;
    wb_seen = 0; rq_seen = 0; done_cnt = 0; wr_cnt = 0; acc_cnt = 0; evict_cnt = 0;
    for (cyc = 0; cyc < 300 && !finished; cyc++) begin
      @(negedge clk);
      miss_valid = !accepted;
      wb_ready = (wb_seen >= wbw);
      fill_req_ready = (rq_seen >= rqw);
      fill_rsp_valid = req_done && !rsp_sent && (cyc - req_cyc >= 1 + fw);
      #1;
      if (!accepted) begin
        chk("miss_ready_idle", miss_ready, 1);
        chk("rd_en_accept", rd_en, 1);
        chk("rd_set_accept", rd_set, s);
        chk("no_dup_done", done, 0);
        accepted = 1;
        acc_cyc = cyc;
      end else begin
        chk("miss_ready_busy", miss_ready, 0);
      end
      if (plru_evict_req) begin
        evict_cnt++;
        chk("evict_req_cycle", cyc, acc_cyc + 2);
      end
      if (wb_valid) begin
        chk("wb_addr", wb_addr, {tg[victim*TAG_W +: TAG_W], s});
        chk("wb_data", wb_data, ld[victim]);
        if (wb_ready) wb_done = 1;
        wb_seen++;
      end
      if (fill_req_valid) begin
        chk("fill_after_wb", wb_done || !exp_wb, 1);
        chk("fill_req_addr", fill_req_addr, {t, s});
        if (fill_req_ready) begin
          req_done = 1;
          req_cyc = cyc;
          if (do_rst) finished = 1;
        end
        rq_seen++;
      end
      if (fill_rsp_valid) rsp_sent = 1;
      if (wr_en) begin
        wr_cnt++;
        chk("wr_set", wr_set, s);
        chk("wr_way", wr_way, victim);
        chk("wr_tag", wr_tag, t);
        chk("wr_state", wr_state, ex ? 2'b10 : 2'b01);
        chk("wr_data", wr_data, fd);
      end
      if (plru_access_valid) begin
        acc_cnt++;
        acc_total++;
        chk("plru_access_way", plru_access_way, victim);
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
        finished = 1;
      end
    end
    chk("miss_timeout", finished, 1);
    if (do_rst) begin
      @(negedge clk);
      miss_valid = 0; fill_req_ready = 0; fill_rsp_valid = 0; rst = 1;
      for (int k = 0; k < 3; k++) begin
        @(negedge clk);
        rst = 0;
        fill_rsp_valid = 1;
        #1;
        chk("rst_miss_ready", miss_ready, 1);
        chk("rst_no_wr_en", wr_en, 0);
        chk("rst_no_done", done, 0);
        chk("rst_no_access", plru_access_valid, 0);
      end
    end else begin
      chk("done_count", done_cnt, 1);
      chk("wr_count", wr_cnt, 1);
      chk("access_count", acc_cnt, 1);
      chk("evict_req_count", evict_cnt, 1);
      chk("wb_occurred", wb_seen != 0, exp_wb);
      if (exp_wb) chk("wb_valid_cycles", wb_seen, wbw + 1);
      chk("miss_latency", done_cyc - acc_cyc, exp_lat);
    end
    fill_rsp_valid = 0;
    wb_ready = 0;
    fill_req_ready = 0;
  endtask

  initial begin
    logic [4*TAG_W-1:0] tg;
    int acc_before;
    rst = 1; miss_valid = 0; miss_set = '0; miss_tag = '0;
    rd_state = '0; rd_tag = '0; rd_data = '0; plru_evict_way = 2'd0;
    wb_ready = 0; fill_req_ready = 0; fill_rsp_valid = 0; fill_rsp_data = '0; fill_rsp_excl = 0;
    repeat (3) @(negedge clk);
    rst = 0;
    #1;
    chk("reset_miss_ready", miss_ready, 1);
    chk("reset_rd_en", rd_en, 0);
    chk("reset_wb_valid", wb_valid, 0);
    chk("reset_fill_req_valid", fill_req_valid, 0);
    chk("reset_wr_en", wr_en, 0);
    chk("reset_done", done, 0);
    chk("reset_evict_req", plru_evict_req, 0);
    chk("reset_access_valid", plru_access_valid, 0);
    chk("reset_wr_set", wr_set, 0);
    chk("reset_wr_tag", wr_tag, 0);
    chk("reset_wr_way", wr_way, 0);

    // Clean victim: {S,E,S,E}, PLRU way 3, exclusive fill.
    tg = {16'($urandom), $urandom, $urandom};
    run_miss(6'd5, 20'h12345, 8'b10_01_10_01, tg, 2'd3, 1'b1, 0, 0, 0, 0);

    // Dirty victim: way 2 Modified with tag 0xABC, writeback stalled 4 cycles.
    tg = {16'($urandom), $urandom, $urandom};
    tg[2*TAG_W +: TAG_W] = 20'h00ABC;
    run_miss(6'd17, 20'h54321, 8'b01_11_10_01, tg, 2'd2, 1'b1, 4, 1, 2, 0);

    // Invalid-first: {S,I,M,S}, PLRU way 2.
    tg = {16'($urandom), $urandom, $urandom};
    run_miss(6'd33, 20'hBEEF1, 8'b01_11_00_01, tg, 2'd2, 1'b0, 0, 0, 0, 0);

    // Long fill latency, shared install.
    tg = {16'($urandom), $urandom, $urandom};
    run_miss(6'd40, 20'h0F0F0, 8'b01_01_01_01, tg, 2'd0, 1'b0, 0, 0, 10, 0);

    // Reset while waiting for fill data.
    tg = {16'($urandom), $urandom, $urandom};
    run_miss(6'd9, 20'h11111, 8'b10_10_10_10, tg, 2'd1, 1'b1, 0, 0, 0, 1);

    // Back-to-back misses.
    acc_before = acc_total;
    tg = {16'($urandom), $urandom, $urandom};
    run_miss(6'd1, 20'hA0A0A, 8'b11_01_10_01, tg, 2'd3, 1'b1, 0, 0, 0, 0);
    tg = {16'($urandom), $urandom, $urandom};
    run_miss(6'd2, 20'hB0B0B, 8'b01_10_01_10, tg, 2'd0, 1'b0, 0, 0, 0, 0);
    chk("b2b_access_pulses", acc_total - acc_before, 2);

    // Random misses.
    for (int n = 0; n < 20; n++) begin
      tg = {16'($urandom), $urandom, $urandom};
      run_miss(6'($urandom), 20'($urandom), 8'($urandom), tg, 2'($urandom), 1'($urandom),
               int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
               int'($urandom_range(0, 4)), 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
